// File: rtl/program_loader.sv
// Boot loader: frames a byte stream into big-endian words, writes them to instruction memory,
// then releases the processor from reset. Define LOADER_CHECKSUM_EN to add a trailing XOR byte.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        error
);

    // One extra bit so a full-depth image (count == DEPTH) can be counted without wrapping.
    localparam int unsigned CntWidth = ADDR_WIDTH + 1;
    localparam logic [16:0] Depth    = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StDone,
        StErr
`ifdef LOADER_CHECKSUM_EN
        , StCsum
`endif
    } state_e;

`ifdef LOADER_CHECKSUM_EN
    localparam state_e StAfterData = StCsum;
`else
    localparam state_e StAfterData = StDone;
`endif

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [CntWidth-1:0]   word_cnt_q, word_cnt_d;
    logic [23:0]           asm_q, asm_d;
    logic                  we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  load_done_q, load_done_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic                  accept;
    logic [15:0]           len_full;
    logic [CntWidth-1:0]   word_next;
    logic [16:0]           word_next_ext;
    logic                  last_word;

    always_comb begin
        rx_ready = 1'b0;
        unique case (state_q)
            StIdle, StLenHi, StLenLo, StData: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            StCsum: rx_ready = 1'b1;
`endif
            default: rx_ready = 1'b0;
        endcase
    end

    assign accept        = rx_valid && rx_ready;
    assign len_full      = {len_q[15:8], rx_byte};
    assign word_next     = word_cnt_q + 1'b1;
    assign word_next_ext = 17'(word_next);
    assign last_word     = (word_next_ext == {1'b0, len_q});

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        asm_d       = asm_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_reset_d = cpu_reset_q;
        load_done_d = load_done_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        if (restart) begin
            // Abort wins over any byte presented in the same cycle; partial word is dropped.
            state_d     = StIdle;
            len_d       = '0;
            byte_cnt_d  = '0;
            word_cnt_d  = '0;
            asm_d       = '0;
            cpu_reset_d = 1'b1;
            load_done_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_d      = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept && (rx_byte == SYNC_BYTE)) begin
                        state_d = StLenHi;
                    end
                end
                StLenHi: begin
                    if (accept) begin
                        len_d[15:8] = rx_byte;
                        state_d     = StLenLo;
                    end
                end
                StLenLo: begin
                    if (accept) begin
                        len_d = len_full;
                        if (len_full == 16'd0) begin
                            state_d = StAfterData;
                        end else if ({1'b0, len_full} > Depth) begin
                            state_d = StErr;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                        csum_d = csum_q ^ rx_byte;
`endif
                        asm_d      = {asm_q[15:0], rx_byte};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            we_d       = 1'b1;
                            wdata_d    = {asm_q, rx_byte};
                            addr_d     = 32'({word_cnt_q[ADDR_WIDTH-1:0], 2'b00});
                            word_cnt_d = word_next;
                            if (last_word) begin
                                state_d = StAfterData;
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                StCsum: begin
                    if (accept) begin
                        state_d = (rx_byte == csum_q) ? StDone : StErr;
                    end
                end
`endif
                StDone: begin
                    // Registered release lands one cycle after the final write or checksum.
                    cpu_reset_d = 1'b0;
                    load_done_d = 1'b1;
                end
                StErr: begin
                    cpu_reset_d = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            asm_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            asm_q       <= asm_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            load_done_q <= load_done_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_done  = load_done_q;
    assign error      = (state_q == StErr);

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames for program_loader, checked against a frame-level model.
module tb_program_loader;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic        restart;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        error;

    program_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_ready   (rx_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int accept_cyc;
    int last_we_cyc;
    int fall_cyc;
    logic prev_cr;
    logic [63:0] wq[$];
    logic [31:0] frame_words[$];

    always @(posedge clk) cyc++;

    // Observe writes and the cpu_reset release edge mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wq.push_back({imem_addr, imem_wdata});
            last_we_cyc = cyc;
        end
        if (prev_cr === 1'b1 && cpu_reset === 1'b0) fall_cyc = cyc;
        prev_cr = cpu_reset;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wq.delete();
        last_we_cyc = -1;
        fall_cyc    = -1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        chk("rx_ready_on_send", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1;
        rx_valid   = 1'b0;
        accept_cyc = cyc;
        repeat (gap) @(negedge clk);
    endtask

    function automatic int pick_gap(input int gmax);
        return (gmax == 0) ? 0 : int'($urandom_range(gmax, 0));
    endfunction

    // Sends SYNC, length, frame_words big-endian and, in checksum builds, the XOR byte.
    task automatic send_frame(input int gmax, input bit csum_good);
        logic [7:0]  x;
        logic [15:0] n;
        logic [31:0] w;
        x = 8'h00;
        n = 16'(frame_words.size());
        send_byte(8'hA5, pick_gap(gmax));
        send_byte(n[15:8], pick_gap(gmax));
        send_byte(n[7:0], pick_gap(gmax));
        foreach (frame_words[i]) begin
            w = frame_words[i];
            for (int k = 3; k >= 0; k--) begin
                x = x ^ w[8*k +: 8];
                send_byte(w[8*k +: 8], pick_gap(gmax));
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum_good ? x : (x ^ 8'h01), pick_gap(gmax));
`else
        if (!csum_good) x = 8'h00;
`endif
    endtask

    task automatic check_writes(input string tag);
        logic [63:0] got;
        chk({tag, "/n_writes"}, 64'(wq.size()), 64'(frame_words.size()));
        foreach (frame_words[i]) begin
            got = (i < wq.size()) ? wq[i] : 64'hx;
            chk({tag, "/write"}, got, {32'(i * 4), frame_words[i]});
        end
    endtask

    task automatic check_loaded(input string tag);
        repeat (3) @(negedge clk);
        check_writes(tag);
        chk({tag, "/cpu_reset"}, 64'(cpu_reset), 64'd0);
        chk({tag, "/load_done"}, 64'(load_done), 64'd1);
        chk({tag, "/error"}, 64'(error), 64'd0);
        chk({tag, "/rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "/release_cycle"}, 64'(fall_cyc), 64'(accept_cyc + 1));
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        @(negedge clk);
        chk("restart/cpu_reset", 64'(cpu_reset), 64'd1);
        chk("restart/load_done", 64'(load_done), 64'd0);
        chk("restart/error", 64'(error), 64'd0);
        clear_mon();
    endtask

    initial begin
        logic [7:0] junk;
        int n;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        restart  = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        chk("reset/cpu_reset", 64'(cpu_reset), 64'd1);
        chk("reset/load_done", 64'(load_done), 64'd0);
        chk("reset/error", 64'(error), 64'd0);
        chk("reset/imem_we", 64'(imem_we), 64'd0);
        chk("reset/imem_addr", 64'(imem_addr), 64'd0);
        chk("reset/imem_wdata", 64'(imem_wdata), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle/rx_ready", 64'(rx_ready), 64'd1);

        // Two-word program
        clear_mon();
        frame_words = '{32'h20080005, 32'hAC080000};
        send_frame(0, 1'b1);
        check_loaded("two_words");
        chk("two_words/last_we_before_release", 64'(last_we_cyc < fall_cyc), 64'd1);

        // Leading junk is ignored
        do_restart();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        frame_words = '{32'hDEADBEEF};
        send_frame(0, 1'b1);
        check_loaded("junk_prefix");

        // Empty image releases the processor straight away
        do_restart();
        frame_words = '{};
        send_frame(0, 1'b1);
        check_loaded("empty");

        // Oversized length
        do_restart();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        repeat (3) @(negedge clk);
        chk("too_long/error", 64'(error), 64'd1);
        chk("too_long/rx_ready", 64'(rx_ready), 64'd0);
        chk("too_long/cpu_reset", 64'(cpu_reset), 64'd1);
        chk("too_long/load_done", 64'(load_done), 64'd0);
        chk("too_long/n_writes", 64'(wq.size()), 64'd0);

        // Restart mid-word, coincident with a valid byte
        do_restart();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = 8'h33;
        restart  = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        restart  = 1'b0;
        send_byte(8'h44, 0);
        repeat (2) @(negedge clk);
        chk("abort/n_writes", 64'(wq.size()), 64'd0);
        chk("abort/cpu_reset", 64'(cpu_reset), 64'd1);
        chk("abort/rx_ready", 64'(rx_ready), 64'd1);
        chk("abort/load_done", 64'(load_done), 64'd0);
        frame_words = '{32'hCAFEBABE};
        send_frame(0, 1'b1);
        check_loaded("after_abort");

        // Asynchronous reset while a write strobe is high
        do_restart();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        chk("async/we_before", 64'(imem_we), 64'd1);
        reset = 1'b1;
        #1;
        chk("async/imem_we", 64'(imem_we), 64'd0);
        chk("async/imem_addr", 64'(imem_addr), 64'd0);
        chk("async/imem_wdata", 64'(imem_wdata), 64'd0);
        chk("async/cpu_reset", 64'(cpu_reset), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        clear_mon();
        frame_words = '{32'h0BADF00D, 32'h600DCAFE};
        send_frame(0, 1'b1);
        check_loaded("after_async");

        // Largest legal image fills memory exactly
        do_restart();
        frame_words = '{};
        for (int i = 0; i < int'(DEPTH); i++) frame_words.push_back($urandom);
        send_frame(0, 1'b1);
        check_loaded("full_depth");

        // Randomized frames with junk prefixes and idle gaps
        for (int t = 0; t < 6; t++) begin
            do_restart();
            n = int'($urandom_range(2, 0));
            for (int j = 0; j < n; j++) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk, pick_gap(2));
            end
            frame_words = '{};
            n = int'($urandom_range(6, 1));
            for (int j = 0; j < n; j++) frame_words.push_back($urandom);
            send_frame(2, 1'b1);
            check_loaded("random");
        end

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum keeps the processor in reset, but words were still written
        do_restart();
        frame_words = '{32'h12345678};
        send_frame(0, 1'b0);
        repeat (3) @(negedge clk);
        check_writes("bad_csum");
        chk("bad_csum/error", 64'(error), 64'd1);
        chk("bad_csum/cpu_reset", 64'(cpu_reset), 64'd1);
        chk("bad_csum/load_done", 64'(load_done), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
